// File: rtl/vga_pattern_gen_mc.sv
// vga_pattern_gen_mc: parametrised VGA/HDMI timing and test-pattern generator.
// Free-running pixel/line counters feed a combinational region/pattern decode
// whose result is captured in a single output register stage, so sync, data
// enable, colour and sof all leave the block mutually aligned. Every
// configuration input is shadowed at counter state (0,0). In that cycle the
// live values are used directly, so a new frame starts with the new settings.
module vga_pattern_gen_mc #(
    parameter int   CW         = 12,
    parameter int   CD         = 8,
    parameter int   NUM_BANDS  = 4,
    parameter int   BAR_SHIFT  = 5,
    parameter int   CHECK_LOG2 = 4,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CW-1:0] h_total,
    input  logic [CW-1:0] h_sync,
    input  logic [CW-1:0] h_start,
    input  logic [CW-1:0] h_end,
    input  logic [CW-1:0] v_total,
    input  logic [CW-1:0] v_sync,
    input  logic [CW-1:0] v_start,
    input  logic [CW-1:0] v_end,
    input  logic [CW-1:0] band_lines,
    input  logic [1:0]    pattern_mode,
    input  logic [3*CD-1:0] solid_rgb,
    input  logic          border_en,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_de,
    output logic [CD-1:0] vga_r,
    output logic [CD-1:0] vga_g,
    output logic [CD-1:0] vga_b,
    output logic          sof,
    output logic [15:0]   frame_cnt
);

    typedef struct packed {
        logic [CW-1:0]   h_total;
        logic [CW-1:0]   h_sync;
        logic [CW-1:0]   h_start;
        logic [CW-1:0]   h_end;
        logic [CW-1:0]   v_total;
        logic [CW-1:0]   v_sync;
        logic [CW-1:0]   v_start;
        logic [CW-1:0]   v_end;
        logic [CW-1:0]   band_lines;
        logic [1:0]      pattern_mode;
        logic [3*CD-1:0] solid_rgb;
        logic            border_en;
    } cfg_t;

    localparam logic [3:0]    BAND_MAX = 4'(NUM_BANDS - 1);
    localparam logic [CD-1:0] FULL     = '1;

    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic [CW-1:0] band_row;
    logic [3:0]    band_idx;

    cfg_t live_cfg;
    cfg_t shadow_cfg;
    cfg_t cfg;

    logic          frame_start;
    logic          h_wrap;
    logic          v_wrap;
    logic          hact;
    logic          vact;
    logic          de_next;
    logic          border;
    logic [CW-1:0] x_pos;
    logic [CW-1:0] y_pos;
    logic [CW-1:0] band_len;
    logic [CD-1:0] ramp;
    logic [2:0]    bar;
    logic [2:0]    bar_bits;
    logic [CD-1:0] r_next;
    logic [CD-1:0] g_next;
    logic [CD-1:0] b_next;

    assign frame_start = (h_count == '0) && (v_count == '0);

    // Gather the live inputs and select live (frame start) or shadowed config.
    always_comb begin
        live_cfg.h_total      = h_total;
        live_cfg.h_sync       = h_sync;
        live_cfg.h_start      = h_start;
        live_cfg.h_end        = h_end;
        live_cfg.v_total      = v_total;
        live_cfg.v_sync       = v_sync;
        live_cfg.v_start      = v_start;
        live_cfg.v_end        = v_end;
        live_cfg.band_lines   = band_lines;
        live_cfg.pattern_mode = pattern_mode;
        live_cfg.solid_rgb    = solid_rgb;
        live_cfg.border_en    = border_en;
        cfg = frame_start ? live_cfg : shadow_cfg;
    end

    // Region decode and active-area coordinates for the current counter state.
    always_comb begin
        h_wrap   = (h_count >= cfg.h_total);
        v_wrap   = (v_count >= cfg.v_total);
        hact     = (h_count >= cfg.h_start) && (h_count < cfg.h_end);
        vact     = (v_count >= cfg.v_start) && (v_count < cfg.v_end);
        de_next  = hact && vact;
        x_pos    = h_count - cfg.h_start;
        y_pos    = v_count - cfg.v_start;
        band_len = (cfg.band_lines == '0) ? CW'(1) : cfg.band_lines;
        border   = cfg.border_en &&
                   ((x_pos == '0) || (h_count == cfg.h_end - CW'(1)) ||
                    (y_pos == '0) || (v_count == cfg.v_end - CW'(1)));
    end

    // Pixel and line counters, each wrapping after its effective total.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_wrap) begin
            h_count <= '0;
            v_count <= v_wrap ? '0 : v_count + CW'(1);
        end else begin
            h_count <= h_count + CW'(1);
        end
    end

    // Capture every configuration input once per frame at state (0,0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_cfg <= '0;
        end else if (frame_start) begin
            shadow_cfg <= live_cfg;
        end
    end

    // Band tracker: advance one band every band_len active lines, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            band_row <= '0;
            band_idx <= '0;
        end else if (h_wrap) begin
            if (v_wrap || !vact) begin
                band_row <= '0;
                band_idx <= '0;
            end else if (band_row >= band_len - CW'(1)) begin
                band_row <= '0;
                if (band_idx < BAND_MAX) begin
                    band_idx <= band_idx + 4'd1;
                end
            end else begin
                band_row <= band_row + CW'(1);
            end
        end
    end

    // Pattern selection; border overrides the mode, blanking forces black.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        r_next   = '0;
        g_next   = '0;
        b_next   = '0;
        ramp     = x_pos[CD-1:0];
        bar      = x_pos[BAR_SHIFT +: 3];
        bar_bits = 3'b000;
        unique case (bar)
            3'd0:    bar_bits = 3'b111;
            3'd1:    bar_bits = 3'b110;
            3'd2:    bar_bits = 3'b011;
            3'd3:    bar_bits = 3'b010;
            3'd4:    bar_bits = 3'b101;
            3'd5:    bar_bits = 3'b100;
            3'd6:    bar_bits = 3'b001;
            default: bar_bits = 3'b000;
        endcase
        if (de_next) begin
            if (border) begin
                r_next = FULL;
                b_next = FULL;
            end else begin
                unique case (cfg.pattern_mode)
                    2'd0: begin
                        unique case (band_idx[1:0])
                            2'd0:    r_next = ramp;
                            2'd1:    g_next = ramp;
                            2'd2:    b_next = ramp;
                            default: begin
                                r_next = ramp;
                                g_next = ramp;
                                b_next = ramp;
                            end
                        endcase
                    end
                    2'd1: begin
                        r_next = {CD{bar_bits[2]}};
                        g_next = {CD{bar_bits[1]}};
                        b_next = {CD{bar_bits[0]}};
                    end
                    2'd2: begin
                        if (!(x_pos[CHECK_LOG2] ^ y_pos[CHECK_LOG2])) begin
                            r_next = FULL;
                            g_next = FULL;
                            b_next = FULL;
                        end
                    end
                    default: begin
                        {r_next, g_next, b_next} = cfg.solid_rgb;
                    end
                endcase
            end
        end
    end

    // Single output register stage plus frame counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_hs    <= ~HS_POL;
            vga_vs    <= ~VS_POL;
            vga_de    <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            sof       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vga_hs <= (h_count < cfg.h_sync) ? HS_POL : ~HS_POL;
            vga_vs <= (v_count < cfg.v_sync) ? VS_POL : ~VS_POL;
            vga_de <= de_next;
            vga_r  <= r_next;
            vga_g  <= g_next;
            vga_b  <= b_next;
            sof    <= frame_start;
            if (frame_start) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
